// File: rtl/rf_write_buffer.sv
// Register-file write buffer: DEPTH-entry FIFO between producers and the single
// register-file write port, with a youngest-first forwarding lookup of pending writes.
module rf_write_buffer #(
    parameter int SIZE  = 16,
    parameter int ADDR  = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR-1:0]          req_addr,
    input  logic [SIZE-1:0]          req_data,
    input  logic                     stall,
    output logic [ADDR-1:0]          rf_write_addr,
    output logic                     rf_write_en,
    output logic [SIZE-1:0]          rf_data_in,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [ADDR-1:0]          lookup_addr,
    output logic                     lookup_hit,
    output logic [SIZE-1:0]          lookup_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR-1:0] mem_addr [DEPTH];
    logic [SIZE-1:0] mem_data [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   idx;
    logic            push;
    logic            pop;

    assign req_ready = (count != CW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (count != '0) && !stall;

    // Storage needs no reset: an entry is only ever read while count covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= req_addr;
            mem_data[wr_ptr] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_data_in    <= '0;
        end else begin
            rf_write_en <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rf_write_addr <= mem_addr[rd_ptr];
                rf_data_in    <= mem_data[rd_ptr];
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Scan oldest to youngest so the last match (the most recent write) wins;
    // the output stage is older than anything still in the FIFO.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        idx         = '0;
        if (rf_write_en && (rf_write_addr == lookup_addr)) begin
            lookup_hit  = 1'b1;
            lookup_data = rf_data_in;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (mem_addr[idx] == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = mem_data[idx];
            end
        end
    end

endmodule

// File: tb/tb_rf_write_buffer.sv
// Scoreboard bench for rf_write_buffer: accepted requests are queued and
// matched, in order, against every register-file write the DUT issues.
module tb_rf_write_buffer;

    localparam int SIZE  = 16;
    localparam int ADDR  = 4;
    localparam int DEPTH = 4;

    logic              clk;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR-1:0]   req_addr;
    logic [SIZE-1:0]   req_data;
    logic              stall;
    logic [ADDR-1:0]   rf_write_addr;
    logic              rf_write_en;
    logic [SIZE-1:0]   rf_data_in;
    logic [2:0]        count;
    logic [ADDR-1:0]   lookup_addr;
    logic              lookup_hit;
    logic [SIZE-1:0]   lookup_data;

    logic [ADDR+SIZE-1:0] sb [$];
    logic [ADDR+SIZE-1:0] exp_e;
    int n_vec = 0;
    int n_err = 0;

    rf_write_buffer #(.SIZE(SIZE), .ADDR(ADDR), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .stall         (stall),
        .rf_write_addr (rf_write_addr),
        .rf_write_en   (rf_write_en),
        .rf_data_in    (rf_data_in),
        .count         (count),
        .lookup_addr   (lookup_addr),
        .lookup_hit    (lookup_hit),
        .lookup_data   (lookup_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADDR-1:0] a, input logic [SIZE-1:0] d);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        for (int t = 0; t < 50; t++) begin
            if (req_ready) begin
                cycle();
                req_valid = 1'b0;
                return;
            end
            cycle();
        end
        check("push_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
    endtask

    // Scoreboard: compare issued writes first, then record the handshake
    // that will complete at the coming rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
        end else begin
            if (rf_write_en) begin
                if (sb.size() == 0) begin
                    check("spurious_write", 32'(rf_write_en), 32'd0);
                end else begin
                    exp_e = sb.pop_front();
                    check("sb_addr", 32'(rf_write_addr), 32'(exp_e[ADDR+SIZE-1:SIZE]));
                    check("sb_data", 32'(rf_data_in), 32'(exp_e[SIZE-1:0]));
                end
            end
            if (req_valid && req_ready) sb.push_back({req_addr, req_data});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_data    = '0;
        stall       = 1'b0;
        lookup_addr = '0;
        cycle();
        cycle();
        check("rst_count", 32'(count), 32'd0);
        check("rst_we", 32'(rf_write_en), 32'd0);
        check("rst_addr", 32'(rf_write_addr), 32'd0);
        check("rst_data", 32'(rf_data_in), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_hit", 32'(lookup_hit), 32'd0);
        reset_n = 1'b1;

        // Single write: accepted at edge 1, issued after edge 2 only.
        req_valid = 1'b1;
        req_addr  = 4'd3;
        req_data  = 16'hBEEF;
        cycle();
        req_valid = 1'b0;
        check("t1_count_e1", 32'(count), 32'd1);
        check("t1_we_e1", 32'(rf_write_en), 32'd0);
        cycle();
        check("t1_we_e2", 32'(rf_write_en), 32'd1);
        check("t1_addr_e2", 32'(rf_write_addr), 32'd3);
        check("t1_data_e2", 32'(rf_data_in), 32'hBEEF);
        check("t1_count_e2", 32'(count), 32'd0);
        cycle();
        check("t1_we_e3", 32'(rf_write_en), 32'd0);
        check("t1_hold_addr", 32'(rf_write_addr), 32'd3);
        check("t1_hold_data", 32'(rf_data_in), 32'hBEEF);

        // Fill under stall, then drain while the refused request waits.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) push(4'(i), 16'(16'h10 + i));
        req_valid = 1'b1;
        req_addr  = 4'd4;
        req_data  = 16'h14;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("full_count", 32'(count), 32'd4);
            check("full_ready", 32'(req_ready), 32'd0);
            check("full_we", 32'(rf_write_en), 32'd0);
        end
        stall = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("drain_we", 32'(rf_write_en), 32'd1);
            check("drain_data", 32'(rf_data_in), 32'(16'h10 + k));
            check("drain_count", 32'(count), (k < 3) ? 32'd3 : 32'(5 - k));
            if (k == 1) begin
                req_addr = 4'd5;
                req_data = 16'h15;
            end
            if (k == 2) req_valid = 1'b0;
        end
        cycle();
        check("drain_we_end", 32'(rf_write_en), 32'd0);

        // Forwarding priority: FIFO youngest, then output stage.
        stall = 1'b1;
        push(4'd7, 16'h1111);
        push(4'd7, 16'h2222);
        lookup_addr = 4'd7;
        #1;
        check("fwd_hit7", 32'(lookup_hit), 32'd1);
        check("fwd_data7", 32'(lookup_data), 32'h2222);
        lookup_addr = 4'd8;
        #1;
        check("fwd_hit8", 32'(lookup_hit), 32'd0);
        check("fwd_data8", 32'(lookup_data), 32'd0);
        lookup_addr = 4'd7;
        stall = 1'b0;
        cycle();
        check("fwd_mixed_data", 32'(lookup_data), 32'h2222);
        cycle();
        check("fwd_out_hit", 32'(lookup_hit), 32'd1);
        check("fwd_out_data", 32'(lookup_data), 32'h2222);
        cycle();
        check("fwd_gone_hit", 32'(lookup_hit), 32'd0);
        lookup_addr = 4'd9;
        req_valid   = 1'b1;
        req_addr    = 4'd9;
        req_data    = 16'hAAAA;
        #1;
        check("fwd_same_cycle", 32'(lookup_hit), 32'd0);
        cycle();
        req_valid = 1'b0;
        check("fwd_fifo_hit", 32'(lookup_hit), 32'd1);
        check("fwd_fifo_data", 32'(lookup_data), 32'hAAAA);
        cycle();
        check("fwd_stage_hit", 32'(lookup_hit), 32'd1);
        check("fwd_stage_data", 32'(lookup_data), 32'hAAAA);
        check("fwd_stage_count", 32'(count), 32'd0);
        cycle();
        check("fwd_stage_gone", 32'(lookup_hit), 32'd0);

        // Back-to-back stream: pointers wrap, count stays at one.
        for (int i = 0; i < 10; i++) begin
            push(4'(i + 2), 16'(16'h100 + i));
            check("stream_count", 32'(count), 32'd1);
            if (i > 0) check("stream_we", 32'(rf_write_en), 32'd1);
        end
        cycle();
        check("stream_last_we", 32'(rf_write_en), 32'd1);
        check("stream_last_data", 32'(rf_data_in), 32'h109);
        cycle();
        check("stream_idle", 32'(rf_write_en), 32'd0);

        // Reset mid-drain discards everything pending.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) push(4'(10 + i), 16'(16'h500 + i));
        stall = 1'b0;
        cycle();
        check("pre_rst_count", 32'(count), 32'd3);
        check("pre_rst_we", 32'(rf_write_en), 32'd1);
        reset_n     = 1'b0;
        lookup_addr = 4'd11;
        cycle();
        reset_n = 1'b1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_we", 32'(rf_write_en), 32'd0);
        check("mid_rst_hit", 32'(lookup_hit), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("post_rst_we", 32'(rf_write_en), 32'd0);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
